// File: rtl/nibble_serial_add_ctrl.sv
// Sequencer that adds two WIDTH-bit operands through one shared external 4-bit adder,
// one nibble per clock, LSB first, with the carry chained through a register.
module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] Op_A,
  input  logic [WIDTH-1:0] Op_B,
  input  logic             Cin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             Cout,
  output logic [3:0]       Add_A,
  output logic [3:0]       Add_B,
  output logic             Add_Cin,
  input  logic [3:0]       Add_Sum,
  input  logic             Add_Cout
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] result_r;
  logic             carry_r;
  logic             cout_r;
  logic             busy_r;
  logic             done_r;
  logic [CNT_W-1:0] cnt_r;

  // Control FSM plus operand/result datapath registers; Start is honoured only in IDLE or DONE.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_r  <= IDLE;
      a_sh_r   <= {WIDTH{1'b0}};
      b_sh_r   <= {WIDTH{1'b0}};
      result_r <= {WIDTH{1'b0}};
      carry_r  <= 1'b0;
      cout_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (Start) begin
            state_r  <= RUN;
            a_sh_r   <= Op_A;
            b_sh_r   <= Op_B;
            carry_r  <= Cin;
            cnt_r    <= {CNT_W{1'b0}};
            result_r <= {WIDTH{1'b0}};
            cout_r   <= 1'b0;
            busy_r   <= 1'b1;
            done_r   <= 1'b0;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end
        end
        RUN: begin
          // Sum nibbles enter at the top so after NIBBLES passes nibble 0 sits at the bottom.
          result_r <= (result_r >> 4) | (WIDTH'(Add_Sum) << (WIDTH - 4));
          carry_r  <= Add_Cout;
          a_sh_r   <= a_sh_r >> 4;
          b_sh_r   <= b_sh_r >> 4;
          if (cnt_r == LAST_NIB) begin
            state_r <= DONE;
            cout_r  <= Add_Cout;
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            cnt_r  <= cnt_r + CNT_W'(1);
            busy_r <= 1'b1;
            done_r <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          cnt_r   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Adder inputs come only from registers and are forced to zero outside RUN.
  always_comb begin
    Add_A   = 4'd0;
    Add_B   = 4'd0;
    Add_Cin = 1'b0;
    if (state_r == RUN) begin
      Add_A   = a_sh_r[3:0];
      Add_B   = b_sh_r[3:0];
      Add_Cin = carry_r;
    end else begin
      Add_A   = 4'd0;
      Add_B   = 4'd0;
      Add_Cin = 1'b0;
    end
  end

  assign Busy   = busy_r;
  assign Done   = done_r;
  assign Result = result_r;
  assign Cout   = cout_r;

endmodule
